// File: rtl/mouse_hit_detector.sv
// Turns left-button clicks into single hit events for the 3x3 mole grid and
// hands them to the game FSM over a valid/ready handshake.
module mouse_hit_detector #(
  parameter int GRID_X0 = 80,
  parameter int GRID_Y0 = 60,
  parameter int CELL_W  = 160,
  parameter int CELL_H  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       left_btn,
  input  logic       hit_ready,
  output logic       hit_valid,
  output logic [3:0] hit_idx,
  output logic       hit_miss,
  output logic [9:0] hit_x,
  output logic [9:0] hit_y,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    PRESENT
  } state_t;

  localparam logic [10:0] X0 = 11'(GRID_X0);
  localparam logic [10:0] Y0 = 11'(GRID_Y0);
  localparam logic [10:0] CW = 11'(CELL_W);
  localparam logic [10:0] CH = 11'(CELL_H);
  localparam logic [1:0]  OUTSIDE = 2'd3;

  state_t     state;
  logic       btn_q;
  logic       click;
  logic [1:0] col;
  logic [1:0] row;
  logic       cls_miss;
  logic [3:0] cls_idx;

  // Bounds are widened to 11 bits so the far edge (origin + 3 cells) never wraps.
  function automatic logic [1:0] axis_cell(input logic [10:0] v,
                                           input logic [10:0] lo,
                                           input logic [10:0] w);
    logic [10:0] b1;
    logic [10:0] b2;
    logic [10:0] b3;
    b1 = lo + w;
    b2 = b1 + w;
    b3 = b2 + w;
    if (v < lo || v >= b3) return OUTSIDE;
    else if (v < b1)       return 2'd0;
    else if (v < b2)       return 2'd1;
    else                   return 2'd2;
  endfunction

  assign click = left_btn & ~btn_q & enable;
  assign busy  = (state != IDLE);

  always_comb begin
    col      = axis_cell({1'b0, hit_x}, X0, CW);
    row      = axis_cell({1'b0, hit_y}, Y0, CH);
    cls_miss = (col == OUTSIDE) || (row == OUTSIDE);
    cls_idx  = cls_miss ? 4'hF : ({2'b00, row} * 4'd3 + {2'b00, col});
  end

  // NOTE: every register here is state, so all updates use <= to avoid
  // order-dependent simulation races between this block and its readers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      btn_q     <= 1'b0;
      hit_valid <= 1'b0;
      hit_idx   <= 4'hF;
      hit_miss  <= 1'b0;
      hit_x     <= '0;
      hit_y     <= '0;
      drop_cnt  <= '0;
    end else begin
      btn_q <= left_btn;
      unique case (state)
        IDLE: begin
          if (click) begin
            hit_x <= x_pos;
            hit_y <= y_pos;
            state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          hit_idx   <= cls_idx;
          hit_miss  <= cls_miss;
          hit_valid <= 1'b1;
          state     <= PRESENT;
          if (click && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        PRESENT: begin
          if (hit_ready) begin
            hit_valid <= 1'b0;
            // A click coinciding with the handshake starts the next event directly.
            if (click) begin
              hit_x <= x_pos;
              hit_y <= y_pos;
              state <= CLASSIFY;
            end else begin
              state <= IDLE;
            end
          end else if (click && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_hit_detector.sv
// Self-checking bench for mouse_hit_detector: directed grid/handshake cases,
// then randomized clicks checked against a transaction-level reference model.
module tb_mouse_hit_detector;

  localparam int GX0 = 80;
  localparam int GY0 = 60;
  localparam int CW  = 160;
  localparam int CH  = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       left_btn;
  logic       hit_ready;
  logic       hit_valid;
  logic [3:0] hit_idx;
  logic       hit_miss;
  logic [9:0] hit_x;
  logic [9:0] hit_y;
  logic [7:0] drop_cnt;
  logic       busy;

  mouse_hit_detector #(
    .GRID_X0(GX0), .GRID_Y0(GY0), .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .left_btn(left_btn),
    .hit_ready(hit_ready), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .hit_miss(hit_miss), .hit_x(hit_x), .hit_y(hit_y),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one event slot with the cycle it becomes visible.
  bit m_prev;
  bit m_occ;
  int m_ready_at;
  int m_x, m_y;
  int m_drops;
  int t;
  int dut_hs;

  function automatic logic [3:0] ref_idx(input int x, input int y);
    if (x < GX0 || x >= GX0 + 3 * CW || y < GY0 || y >= GY0 + 3 * CH) return 4'hF;
    return 4'(((y - GY0) / CH) * 3 + (x - GX0) / CW);
  endfunction

  function automatic void model_reset();
    m_prev  = 1'b0;
    m_occ   = 1'b0;
    m_drops = 0;
  endfunction

  // Applies one cycle of inputs (called at negedge), advances the model,
  // then compares outputs at the following negedge.
  task automatic step(input bit btn, input int x, input int y, input bit en, input bit rdy);
    bit e;
    bit shown;
    bit vis;
    left_btn  = btn;
    x_pos     = x[9:0];
    y_pos     = y[9:0];
    enable    = en;
    hit_ready = rdy;
    if (hit_valid && rdy) dut_hs++;
    t++;
    e      = btn && !m_prev && en;
    m_prev = btn;
    shown  = m_occ && (t - 1 >= m_ready_at);
    if (!m_occ) begin
      if (e) begin
        m_occ = 1'b1; m_x = x; m_y = y; m_ready_at = t + 1;
      end
    end else if (shown && rdy) begin
      if (e) begin
        m_x = x; m_y = y; m_ready_at = t + 1;
      end else begin
        m_occ = 1'b0;
      end
    end else if (e && m_drops < 255) begin
      m_drops++;
    end
    @(posedge clk);
    @(negedge clk);
    vis = m_occ && (t >= m_ready_at);
    check("valid", hit_valid, vis);
    check("busy", busy, m_occ);
    check("drop_cnt", drop_cnt, m_drops);
    if (vis) begin
      check("idx", hit_idx, ref_idx(m_x, m_y));
      check("miss", hit_miss, ref_idx(m_x, m_y) == 4'hF);
      check("hit_x", hit_x, m_x);
      check("hit_y", hit_y, m_y);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, hit_valid, 0);
    check({tag, "_idx"}, hit_idx, 4'hF);
    check({tag, "_miss"}, hit_miss, 0);
    check({tag, "_x"}, hit_x, 0);
    check({tag, "_y"}, hit_y, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    left_btn = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Click with hit_ready high; checks the 2-cycle latency and the table index.
  task automatic click_accept(input int x, input int y, input logic [3:0] exp_idx);
    step(0, x, y, 1, 1);
    step(1, x, y, 1, 1);
    check("lat_n1_valid", hit_valid, 0);
    step(1, x, y, 1, 1);
    check("lat_n2_valid", hit_valid, 1);
    check("tbl_idx", hit_idx, exp_idx);
    check("tbl_miss", hit_miss, exp_idx == 4'hF);
    check("tbl_x", hit_x, x);
    check("tbl_y", hit_y, y);
    step(0, x, y, 1, 1);
    check("accept_valid", hit_valid, 0);
    check("accept_busy", busy, 0);
  endtask

  typedef struct { int x; int y; logic [3:0] idx; } pt_t;
  pt_t table_pts[7];

  initial begin
    int hs0;
    bit rb;
    int rx, ry;

    table_pts[0] = '{320, 240, 4'd4};
    table_pts[1] = '{80, 60, 4'd0};
    table_pts[2] = '{239, 179, 4'd0};
    table_pts[3] = '{240, 179, 4'd1};
    table_pts[4] = '{559, 419, 4'd8};
    table_pts[5] = '{560, 419, 4'hF};
    table_pts[6] = '{79, 200, 4'hF};

    reset = 1'b1; enable = 1'b1; left_btn = 1'b0; hit_ready = 1'b0;
    x_pos = '0; y_pos = '0;
    t = 0; dut_hs = 0; m_ready_at = 0; m_x = 0; m_y = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    foreach (table_pts[i]) click_accept(table_pts[i].x, table_pts[i].y, table_pts[i].idx);

    // Backpressure: one held event, three dropped clicks.
    step(1, 100, 100, 1, 0);
    step(0, 100, 100, 1, 0);
    repeat (3) begin
      step(1, 500, 400, 1, 0);
      step(0, 500, 400, 1, 0);
    end
    check("bp_drops", drop_cnt, 3);
    check("bp_hold_x", hit_x, 100);
    check("bp_hold_idx", hit_idx, 0);
    step(0, 0, 0, 1, 1);
    check("bp_release_valid", hit_valid, 0);
    check("bp_release_busy", busy, 0);

    // Handshake coinciding with a new click: no drop, new event 2 cycles on.
    step(1, 300, 100, 1, 0);
    step(0, 300, 100, 1, 0);
    step(1, 450, 350, 1, 1);
    check("same_cyc_drops", drop_cnt, 3);
    step(1, 450, 350, 1, 0);
    check("same_cyc_valid", hit_valid, 1);
    check("same_cyc_x", hit_x, 450);
    check("same_cyc_idx", hit_idx, 4'd8);
    step(0, 0, 0, 1, 1);

    async_reset("rst2");

    // Button held for 1000 cycles yields exactly one event.
    hs0 = dut_hs;
    repeat (1000) step(1, 320, 240, 1, 1);
    step(0, 320, 240, 1, 1);
    check("hold_events", dut_hs - hs0, 1);

    // Disabled capture: no events and nothing counted.
    repeat (5) begin
      step(1, 320, 240, 0, 0);
      step(0, 320, 240, 0, 0);
    end
    check("en_busy", busy, 0);
    check("en_drops", drop_cnt, 0);

    // Drop counter saturation, then asynchronous reset while presenting.
    step(1, 200, 200, 1, 0);
    step(0, 200, 200, 1, 0);
    repeat (300) begin
      step(1, 600, 10, 1, 0);
      step(0, 600, 10, 1, 0);
    end
    check("sat_drops", drop_cnt, 255);
    check("sat_valid", hit_valid, 1);
    async_reset("rst3");
    click_accept(320, 240, 4'd4);

    // Randomized traffic with occasional mid-flight resets.
    rb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rb = ~rb;
      rx = ($urandom_range(0, 3) != 0) ? int'($urandom_range(40, 600)) : int'($urandom_range(0, 1023));
      ry = ($urandom_range(0, 3) != 0) ? int'($urandom_range(30, 450)) : int'($urandom_range(0, 1023));
      step(rb, rx, ry, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
      if (i % 1000 == 999) begin
        async_reset("rst_rand");
        rb = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
